// File: rtl/exp_align_pipe.sv
// exp_align_pipe
//
// Exponent compare and mantissa alignment stage for the FP add/sub datapath.
// It takes two biased exponents with their mantissas and works out which
// operand has the larger exponent ("big"). The smaller-exponent mantissa is
// right-shifted by the exponent difference so that it lines up with the big
// mantissa.
//
// The block is an elastic valid/ready pipeline:
//   - 2-cycle latency from input handshake to out_valid_o.
//   - One operation per cycle when not stalled.
//   - Reset is asynchronous and active-high.
//
// Build option:
//   ALIGN_GRS_EN  When defined, man_small_o is MAN_W+3 bits wide:
//                 {aligned mantissa, guard, round, sticky}.
//                 When undefined, man_small_o is MAN_W bits wide and the
//                 bits shifted out are dropped.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   in_valid_i     operand pair valid
//   in_ready_o     operand pair accepted this cycle when in_valid_i is high
//   exp_a_i/exp_b_i  biased exponents of operands A and B
//   man_a_i/man_b_i  mantissas of A and B, hidden bit included
//   out_valid_o    result valid
//   out_ready_i    downstream takes the result
//   exp_max_o      larger exponent
//   man_big_o      mantissa of the larger-exponent operand, unshifted
//   man_small_o    aligned smaller mantissa (plus GRS bits when enabled)
//   shift_amt_o    shift applied, saturated to MAN_W
//   swap_o         1 when B is the big operand
//   eq_exp_o       exponents are equal
//   too_far_o      exponent difference >= MAN_W; aligned mantissa is zero
module exp_align_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 24,
    parameter int unsigned SH_W  = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [EXP_W-1:0] exp_a_i,
    input  logic [EXP_W-1:0] exp_b_i,
    input  logic [MAN_W-1:0] man_a_i,
    input  logic [MAN_W-1:0] man_b_i,

    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [EXP_W-1:0] exp_max_o,
    output logic [MAN_W-1:0] man_big_o,
`ifdef ALIGN_GRS_EN
    output logic [MAN_W+2:0] man_small_o,
`else
    output logic [MAN_W-1:0] man_small_o,
`endif
    output logic [SH_W-1:0]  shift_amt_o,
    output logic             swap_o,
    output logic             eq_exp_o,
    output logic             too_far_o
);

`ifdef ALIGN_GRS_EN
    localparam int unsigned G = 3;
`else
    localparam int unsigned G = 0;
`endif
    localparam int unsigned SMALL_W = MAN_W + G;
    localparam logic [SH_W-1:0] ShSat = SH_W'(MAN_W);

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic adv2;
    logic load1;
    logic load2;

    always_comb begin
        // Stage 2 can take new data if it is empty or is being drained now.
        adv2       = !v2_q || out_ready_i;
        // Equivalent to !v1 | !v2 | out_ready.
        in_ready_o = !v1_q || adv2;
        load1      = in_valid_i && in_ready_o;
        load2      = v1_q && adv2;
        v1_d       = load1 || (v1_q && !adv2);
        v2_d       = adv2 ? v1_q : v2_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: compare, swap, shift amount
    // ------------------------------------------------------------------
    logic [EXP_W:0]   diff;
    logic [EXP_W:0]   mag;
    logic             s1_swap;
    logic             s1_eq;
    logic             s1_too_far;
    logic [SH_W-1:0]  s1_shift;
    logic [EXP_W-1:0] s1_exp_max;
    logic [MAN_W-1:0] s1_man_big;
    logic [MAN_W-1:0] s1_man_small;

    always_comb begin
        // The extra top bit is the borrow, which means B > A.
        diff         = {1'b0, exp_a_i} - {1'b0, exp_b_i};
        s1_swap      = diff[EXP_W];
        mag          = s1_swap ? (~diff + 1'b1) : diff;
        s1_eq        = (diff == '0);
        s1_too_far   = (32'(mag) >= MAN_W);
        s1_shift     = s1_too_far ? ShSat : SH_W'(mag);
        s1_exp_max   = s1_swap ? exp_b_i : exp_a_i;
        s1_man_big   = s1_swap ? man_b_i : man_a_i;
        s1_man_small = s1_swap ? man_a_i : man_b_i;
    end

    logic [EXP_W-1:0] exp_max1_q;
    logic [MAN_W-1:0] man_big1_q;
    logic [MAN_W-1:0] man_small1_q;
    logic [SH_W-1:0]  shift1_q;
    logic             swap1_q;
    logic             eq1_q;
    logic             too_far1_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exp_max1_q   <= '0;
            man_big1_q   <= '0;
            man_small1_q <= '0;
            shift1_q     <= '0;
            swap1_q      <= 1'b0;
            eq1_q        <= 1'b0;
            too_far1_q   <= 1'b0;
        end else if (load1) begin
            exp_max1_q   <= s1_exp_max;
            man_big1_q   <= s1_man_big;
            man_small1_q <= s1_man_small;
            shift1_q     <= s1_shift;
            swap1_q      <= s1_swap;
            eq1_q        <= s1_eq;
            too_far1_q   <= s1_too_far;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: barrel right shift of the small mantissa
    // ------------------------------------------------------------------
    logic [SMALL_W-1:0] s2_man_small;

`ifdef ALIGN_GRS_EN
    // The mantissa sits in the upper half, so the bits shifted out collect
    // in the lower half and give guard, round and sticky.
    logic [2*MAN_W-1:0] sh_wide;

    always_comb begin
        sh_wide = {man_small1_q, {MAN_W{1'b0}}};
        for (int k = 0; k < int'(SH_W); k++) begin
            if (shift1_q[k]) begin
                sh_wide = sh_wide >> (1 << k);
            end
        end
        if (too_far1_q) begin
            s2_man_small = {{MAN_W{1'b0}}, 2'b00, |man_small1_q};
        end else begin
            s2_man_small = {sh_wide[2*MAN_W-1:MAN_W], sh_wide[MAN_W-1], sh_wide[MAN_W-2],
                            |sh_wide[MAN_W-3:0]};
        end
    end
`else
    logic [MAN_W-1:0] sh_narrow;

    always_comb begin
        sh_narrow = man_small1_q;
        for (int k = 0; k < int'(SH_W); k++) begin
            if (shift1_q[k]) begin
                sh_narrow = sh_narrow >> (1 << k);
            end
        end
        s2_man_small = too_far1_q ? '0 : sh_narrow;
    end
`endif

    logic             out_valid_q;
    logic [EXP_W-1:0] exp_max_q;
    logic [MAN_W-1:0] man_big_q;
    logic [SMALL_W-1:0] man_small_q;
    logic [SH_W-1:0]  shift_amt_q;
    logic             swap_q;
    logic             eq_exp_q;
    logic             too_far_q;

    assign out_valid_q = v2_q;

    // Output data only changes when stage 2 loads, so it holds under stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exp_max_q   <= '0;
            man_big_q   <= '0;
            man_small_q <= '0;
            shift_amt_q <= '0;
            swap_q      <= 1'b0;
            eq_exp_q    <= 1'b0;
            too_far_q   <= 1'b0;
        end else if (load2) begin
            exp_max_q   <= exp_max1_q;
            man_big_q   <= man_big1_q;
            man_small_q <= s2_man_small;
            shift_amt_q <= shift1_q;
            swap_q      <= swap1_q;
            eq_exp_q    <= eq1_q;
            too_far_q   <= too_far1_q;
        end
    end

    always_comb begin
        out_valid_o = out_valid_q;
        exp_max_o   = exp_max_q;
        man_big_o   = man_big_q;
        man_small_o = man_small_q;
        shift_amt_o = shift_amt_q;
        swap_o      = swap_q;
        eq_exp_o    = eq_exp_q;
        too_far_o   = too_far_q;
    end

endmodule

// File: tb/tb_exp_align_pipe.sv
// Directed testbench for exp_align_pipe. Expected results go into a scoreboard
// queue when an operand pair is accepted. A monitor pops the queue and compares
// each time the DUT hands over a result.
module tb_exp_align_pipe;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 24;
    localparam int unsigned SH_W  = 5;
`ifdef ALIGN_GRS_EN
    localparam int unsigned G = 3;
`else
    localparam int unsigned G = 0;
`endif
    localparam int unsigned MSW = MAN_W + G;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [MAN_W-1:0] man_a;
    logic [MAN_W-1:0] man_b;
    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] exp_max;
    logic [MAN_W-1:0] man_big;
    logic [MSW-1:0]   man_small;
    logic [SH_W-1:0]  shift_amt;
    logic             swap;
    logic             eq_exp;
    logic             too_far;

    exp_align_pipe #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W),
        .SH_W (SH_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .exp_a_i    (exp_a),
        .exp_b_i    (exp_b),
        .man_a_i    (man_a),
        .man_b_i    (man_b),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .exp_max_o  (exp_max),
        .man_big_o  (man_big),
        .man_small_o(man_small),
        .shift_amt_o(shift_amt),
        .swap_o     (swap),
        .eq_exp_o   (eq_exp),
        .too_far_o  (too_far)
    );

    always #5 clk = ~clk;

    // smf holds {aligned mantissa, guard, round, sticky}. Without GRS only
    // the top MAN_W bits are compared.
    typedef struct packed {
        logic [7:0]  em;
        logic [23:0] big;
        logic [26:0] smf;
        logic [4:0]  sh;
        logic        sw;
        logic        eq;
        logic        tf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;
    logic done3;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] em, input logic [23:0] big,
                                input logic [23:0] smant, input logic [2:0] grs,
                                input logic [4:0] sh, input logic sw, input logic eq,
                                input logic tf);
        exp_t e;
        e.em  = em;
        e.big = big;
        e.smf = {smant, grs};
        e.sh  = sh;
        e.sw  = sw;
        e.eq  = eq;
        e.tf  = tf;
        return e;
    endfunction

    // Called just after a negedge. Returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] ea, input logic [7:0] eb, input logic [23:0] ma,
                        input logic [23:0] mb, input exp_t e);
        logic acc;
        int   n;
        in_valid = 1'b1;
        exp_a    = ea;
        exp_b    = eb;
        man_a    = ma;
        man_b    = mb;
        acc      = 1'b0;
        n        = 0;
        do begin
            #1;
            acc = in_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            chk("accept_timeout", 64'(acc), 64'd1);
        end else begin
            sb.push_back(e);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    // Monitor
    exp_t e;
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got exp_max 0x%0h, expected no result", exp_max);
            end else begin
                e = sb.pop_front();
                pops++;
                chk("exp_max", 64'(exp_max), 64'(e.em));
                chk("man_big", 64'(man_big), 64'(e.big));
                chk("man_small", 64'(man_small), 64'(e.smf >> (3 - G)));
                chk("shift_amt", 64'(shift_amt), 64'(e.sh));
                chk("swap", 64'(swap), 64'(e.sw));
                chk("eq_exp", 64'(eq_exp), 64'(e.eq));
                chk("too_far", 64'(too_far), 64'(e.tf));
            end
        end
    end

    exp_t v1, v2, v3, v4, v5, v6, v7;
    int   p0;

    initial begin
        in_valid  = 1'b0;
        exp_a     = '0;
        exp_b     = '0;
        man_a     = '0;
        man_b     = '0;
        out_ready = 1'b1;
        done3     = 1'b0;

        v1 = mk(8'h85, 24'h800000, 24'h180000, 3'b000, 5'd3,  1'b0, 1'b0, 1'b0);
        v2 = mk(8'h7F, 24'h123456, 24'h000000, 3'b001, 5'd24, 1'b1, 1'b0, 1'b1);
        v3 = mk(8'h40, 24'h900000, 24'hA5A5A5, 3'b000, 5'd0,  1'b0, 1'b1, 1'b0);
        v4 = mk(8'h97, 24'h800000, 24'h000001, 3'b111, 5'd23, 1'b0, 1'b0, 1'b0);
        v5 = mk(8'h98, 24'hC00000, 24'h000000, 3'b001, 5'd24, 1'b0, 1'b0, 1'b1);
        v6 = mk(8'h83, 24'h800000, 24'h000001, 3'b111, 5'd3,  1'b0, 1'b0, 1'b0);
        v7 = mk(8'h82, 24'hF00000, 24'h200000, 3'b010, 5'd2,  1'b1, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_exp_max", 64'(exp_max), 64'd0);
        chk("reset_man_big", 64'(man_big), 64'd0);
        chk("reset_man_small", 64'(man_small), 64'd0);
        chk("reset_shift_amt", 64'(shift_amt), 64'd0);

        // Back-to-back directed vectors, streaming.
        send(8'h85, 8'h82, 24'h800000, 24'hC00000, v1);
        send(8'h10, 8'h7F, 24'hABCDEF, 24'h123456, v2);
        send(8'h40, 8'h40, 24'h900000, 24'hA5A5A5, v3);
        send(8'h97, 8'h80, 24'h800000, 24'hFFFFFF, v4);
        send(8'h98, 8'h80, 24'hC00000, 24'hFFFFFF, v5);
        send(8'h83, 8'h80, 24'h800000, 24'h00000F, v6);
        send(8'h80, 8'h82, 24'h800001, 24'hF00000, v7);
        // Bubble, then a single op to check the latency.
        @(negedge clk);
        @(negedge clk);
        wait_drain();
        send(8'h80, 8'h82, 24'h800001, 24'hF00000, v7);
        #2;
        chk("latency_1edge_not_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        #2;
        chk("latency_2edge_valid", 64'(out_valid), 64'd1);
        wait_drain();

        // Stall: three ops offered while the output is blocked.
        out_ready = 1'b0;
        fork
            begin
                send(8'h85, 8'h82, 24'h800000, 24'hC00000, v1);
                send(8'h80, 8'h82, 24'h800001, 24'hF00000, v7);
                send(8'h40, 8'h40, 24'h900000, 24'hA5A5A5, v3);
                done3 = 1'b1;
            end
        join_none
        repeat (4) @(negedge clk);
        #3;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_head_held", 64'(exp_max), 64'h85);
        chk("stall_accepted", 64'(sb.size()), 64'd2);
        p0 = pops;
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        chk("stall_drain_rate", 64'(pops - p0), 64'd3);
        chk("stall_all_sent", 64'(done3), 64'd1);
        wait_drain();

        // Asynchronous reset with two ops in flight.
        out_ready = 1'b0;
        send(8'h40, 8'h40, 24'h900000, 24'hA5A5A5, v3);
        send(8'h83, 8'h80, 24'h800000, 24'h00000F, v6);
        #3;
        chk("inflight_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_reset_out_valid", 64'(out_valid), 64'd0);
        chk("async_reset_exp_max", 64'(exp_max), 64'd0);
        sb.delete();
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            chk("no_stale_result", 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        send(8'h83, 8'h80, 24'h800000, 24'h00000F, v6);
        #2;
        chk("post_reset_1edge", 64'(out_valid), 64'd0);
        @(negedge clk);
        #2;
        chk("post_reset_2edge", 64'(out_valid), 64'd1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp_align_pipe.md
Name: exp_align_pipe

Overview:
- Parametrised, pipelined successor to the floating-point exponent comparator.
- Compares two biased exponents, swaps operands so the larger-exponent operand is "big", and right-aligns the smaller mantissa by the exponent difference.
- Sits between operand unpack and the mantissa adder in the FP add/sub datapath.
- Valid/ready elastic pipeline, 2-cycle latency, one operation per cycle throughput.

Parameters:
- EXP_W, 8: exponent width (biased, unsigned).
- MAN_W, 24: mantissa width including hidden bit.
- SH_W, 5: shift-amount width; requires 2^SH_W > MAN_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operand pair this cycle.
- exp_a  input  EXP_W  exponent of operand A.
- exp_b  input  EXP_W  exponent of operand B.
- man_a  input  MAN_W  mantissa of A.
- man_b  input  MAN_W  mantissa of B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- exp_max  output  EXP_W  larger exponent.
- man_big  output  MAN_W  mantissa of larger-exponent operand, unshifted.
- man_small  output  MAN_W+G  aligned smaller mantissa; G=3 with ALIGN_GRS_EN, else G=0.
- shift_amt  output  SH_W  applied shift, saturated to MAN_W.
- swap  output  1  1 when exp_b > exp_a (B is big).
- eq_exp  output  1  exponents equal.
- too_far  output  1  |exp_a-exp_b| >= MAN_W; man_small forced to 0 (except sticky).

Behaviour:
- Reset: out_valid=0 and internal stage valids=0 immediately on rst assertion, independent of clk. All data outputs=0. in_ready=1 once out of reset. A reset mid-operation discards in-flight data; nothing from before reset ever appears on the output.
- Stage 1 (register on accept):
  - diff = exp_a - exp_b in EXP_W+1 bits.
  - swap = borrow bit; magnitude = two's-complement of diff when swap=1.
  - Ties: equal exponents give swap=0, so A is big.
  - Select big/small mantissas; compute too_far = (magnitude >= MAN_W); shift = too_far ? MAN_W : magnitude[SH_W-1:0].
- Stage 2: barrel right-shift small mantissa by shift (zero fill), then register all outputs.
- Latency: exactly 2 clk edges from input handshake to out_valid when unstalled.
- Handshake:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Stage 2 loads when empty or being drained in the same cycle.
  - Stage 1 loads when empty or advancing into stage 2 in the same cycle.
  - in_ready = !v1 | !v2 | out_ready (combinational).
  - Outputs hold stable while out_valid & !out_ready.
  - Max 2 operations in flight; order preserved, no drop or duplication.
- Simultaneous accept and drain in the same cycle sustains full throughput.
- in_valid=0 creates bubbles; bubbles do not stall later data.

Optional Feature:
- ALIGN_GRS_EN defined:
  - man_small is MAN_W+3 bits: {shifted mantissa, guard, round, sticky}.
  - guard and round are the first two bits shifted out.
  - sticky is the OR of all remaining shifted-out bits.
  - When too_far=1: guard=round=0 and sticky = OR of the entire small mantissa.
- Undefined: man_small is MAN_W bits and shifted-out bits are discarded.

Test Plan:
- exp_a=0x85, exp_b=0x82, man_a=0x800000, man_b=0xC00000 -> 2 cycles later: exp_max=0x85, swap=0, shift_amt=3, man_big=0x800000, man_small=0x180000, too_far=0, eq_exp=0.
- exp_a=0x10, exp_b=0x7F, man_a=0xABCDEF -> swap=1, too_far=1, shift_amt=24, man_big=man_b, man_small=0; with ALIGN_GRS_EN, low GRS bits=001.
- exp_a=exp_b=0x40 -> swap=0, eq_exp=1, shift_amt=0, man_small=man_b. Boundary cases:
  - exp_a=0x97, exp_b=0x80, man_b=0xFFFFFF -> too_far=0, shift_amt=23, man_small=0x000001.
  - exp_a=0x98, exp_b=0x80 -> too_far=1.
- ALIGN_GRS_EN, exp_a=0x83, exp_b=0x80, man_b=0x00000F -> man_small mantissa=0x000001, GRS=111.
- Back-to-back 3 inputs with out_ready=0 for 4 cycles -> in_ready deasserts after 2 accepted, third held; after out_ready=1, all three results emerge in order, one per cycle, none lost.
- rst pulsed asynchronously while 2 ops in flight -> out_valid falls immediately; after release, no stale result appears and a new op completes in 2 cycles.
